// File: rtl/icache_pkg.sv
// Shared constants and FSM state encoding for the instruction-cache boot loader.
package icache_pkg;

    localparam int ICACHE_DEPTH   = 128;
    localparam int ICACHE_INDEX_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        RX_LO,
        RX_HI,
        WRITE,
        RX_SUM,
        FINISH
    } loader_state_e;

endpackage

// File: rtl/icache_loader.sv
// Instruction-cache boot/reload controller: assembles a little-endian byte stream into
// 16-bit words written at consecutive cache indices. Optional trailing XOR checksum: ICACHE_LOADER_CHECKSUM_EN.
module icache_loader
    import icache_pkg::*;
#(
    parameter int DEPTH = ICACHE_DEPTH,
    parameter int LEN_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [LEN_W-1:0]          load_len,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      rx_ready,
    output logic                      ic_write,
    output logic [ICACHE_INDEX_W-1:0] ic_instruction_index,
    output logic [15:0]               ic_instruction,
    input  logic                      cpu_fetch,
    input  logic [ICACHE_INDEX_W-1:0] cpu_index,
    output logic [ICACHE_INDEX_W-1:0] ic_index,
    output logic                      ic_not_enable,
    output logic                      cpu_stall,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W+1)'(DEPTH);

    loader_state_e    state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [7:0]       lo_q;
    logic             rx_fire;
    logic             last_word;
`ifdef ICACHE_LOADER_CHECKSUM_EN
    logic [7:0]       sum_q;
`endif

    assign rx_fire   = rx_valid && rx_ready;
    assign last_word = ({1'b0, cnt} + 1'b1) == {1'b0, len_q};

    // The read port is always steered by the CPU; only its enable is withheld during a load.
    assign ic_index      = cpu_index;
    assign ic_not_enable = busy || !cpu_fetch;
    assign cpu_stall     = busy;

    // NOTE: every state bit and registered output uses <= so all of them update from
    // the same pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            len_q                <= '0;
            cnt                  <= '0;
            lo_q                 <= '0;
            rx_ready             <= 1'b0;
            ic_write             <= 1'b0;
            ic_instruction_index <= '0;
            ic_instruction       <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            error                <= 1'b0;
`ifdef ICACHE_LOADER_CHECKSUM_EN
            sum_q                <= '0;
`endif
        end else begin
            done     <= 1'b0;
            ic_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if ({1'b0, load_len} > DEPTH_L) begin
                            error <= 1'b1;
                        end else begin
                            len_q <= load_len;
                            cnt   <= '0;
                            error <= 1'b0;
                            busy  <= 1'b1;
`ifdef ICACHE_LOADER_CHECKSUM_EN
                            sum_q <= '0;
`endif
                            if (load_len == '0) begin
`ifdef ICACHE_LOADER_CHECKSUM_EN
                                state    <= RX_SUM;
                                rx_ready <= 1'b1;
`else
                                state    <= FINISH;
                                done     <= 1'b1;
`endif
                            end else begin
                                state    <= RX_LO;
                                rx_ready <= 1'b1;
                            end
                        end
                    end
                end
                RX_LO: begin
                    if (rx_fire) begin
                        lo_q  <= rx_data;
                        state <= RX_HI;
`ifdef ICACHE_LOADER_CHECKSUM_EN
                        sum_q <= sum_q ^ rx_data;
`endif
                    end
                end
                RX_HI: begin
                    // Write strobe and data are launched together so they are stable before the cache's negedge sample.
                    if (rx_fire) begin
                        rx_ready             <= 1'b0;
                        ic_write             <= 1'b1;
                        ic_instruction_index <= ICACHE_INDEX_W'(cnt);
                        ic_instruction       <= {rx_data, lo_q};
                        state                <= WRITE;
`ifdef ICACHE_LOADER_CHECKSUM_EN
                        sum_q                <= sum_q ^ rx_data;
`endif
                    end
                end
                WRITE: begin
                    cnt <= cnt + 1'b1;
                    if (last_word) begin
`ifdef ICACHE_LOADER_CHECKSUM_EN
                        state    <= RX_SUM;
                        rx_ready <= 1'b1;
`else
                        state    <= FINISH;
                        done     <= 1'b1;
`endif
                    end else begin
                        state    <= RX_LO;
                        rx_ready <= 1'b1;
                    end
                end
`ifdef ICACHE_LOADER_CHECKSUM_EN
                RX_SUM: begin
                    if (rx_fire) begin
                        if (rx_data != sum_q) begin
                            error <= 1'b1;
                        end
                        rx_ready <= 1'b0;
                        done     <= 1'b1;
                        state    <= FINISH;
                    end
                end
`endif
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    rx_ready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_loader.sv
// Self-checking bench for icache_loader: randomized byte streams against a queue-based
// model of expected cache writes, busy length and done/error outcome.
module tb_icache_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  load_len;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        ic_write;
    logic [31:0] ic_instruction_index;
    logic [15:0] ic_instruction;
    logic        cpu_fetch;
    logic [31:0] cpu_index;
    logic [31:0] ic_index;
    logic        ic_not_enable;
    logic        cpu_stall;
    logic        busy;
    logic        done;
    logic        error;

    icache_loader dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .load_len             (load_len),
        .rx_valid             (rx_valid),
        .rx_data              (rx_data),
        .rx_ready             (rx_ready),
        .ic_write             (ic_write),
        .ic_instruction_index (ic_instruction_index),
        .ic_instruction       (ic_instruction),
        .cpu_fetch            (cpu_fetch),
        .cpu_index            (cpu_index),
        .ic_index             (ic_index),
        .ic_not_enable        (ic_not_enable),
        .cpu_stall            (cpu_stall),
        .busy                 (busy),
        .done                 (done),
        .error                (error)
    );

    typedef struct {
        int          idx;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  fixed_q[$];
    logic [15:0] cache_mem [0:127];
    int          errors = 0;
    int          checks = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          wr_cnt = 0;
    bit          rand_cpu = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sole driver of the CPU fetch inputs; random traffic unless pinned to fetch index 5.
    always @(posedge clk) begin
        #1;
        if (rand_cpu) begin
            cpu_fetch = 1'($urandom);
            cpu_index = $urandom;
        end else begin
            cpu_fetch = 1'b1;
            cpu_index = 32'd5;
        end
    end

    // Compare process: sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        wr_t e;
        check("pass_index", ic_index, cpu_index);
        check("not_enable", 32'(ic_not_enable), 32'(busy || !cpu_fetch));
        check("stall", 32'(cpu_stall), 32'(busy));
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (ic_write) begin
            wr_cnt++;
            cache_mem[ic_instruction_index[6:0]] = ic_instruction;
            check("ready_in_write", 32'(rx_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_index", ic_instruction_index, 32'(e.idx));
                check("wr_data", 32'(ic_instruction), 32'(e.data));
            end
        end
    end

    // One load: gap>=0 is a fixed idle gap before every byte, gap<0 a random gap up to -gap.
    // restart_at pulses a stray start with that byte; abort_wr>0 resets after that many writes.
    task automatic run_load(input int len, input int gap, input int restart_at,
                            input bit bad_sum, input int abort_wr);
        logic [7:0] bytes[$];
        logic [7:0] sum;
        int         extra, d0, w0, g, t, exp_busy;
        bit         rdy, exp_err;
        sum   = 8'h00;
        extra = 0;
        for (int i = 0; i < 2*len; i++) begin
            logic [7:0] b;
            b = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
            bytes.push_back(b);
            sum ^= b;
        end
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{idx: i, data: {bytes[2*i+1], bytes[2*i]}});
        end
`ifdef ICACHE_LOADER_CHECKSUM_EN
        bytes.push_back(bad_sum ? ((sum == 8'h00) ? 8'hff : 8'h00) : sum);
        exp_err  = bad_sum;
        exp_busy = 3*len + 2;
`else
        exp_err  = 1'b0;
        exp_busy = 3*len + 1;
        if (bad_sum) $display("note: checksum feature not built, bad_sum ignored");
`endif
        d0       = done_cnt;
        w0       = wr_cnt;
        busy_cnt = 0;
        @(posedge clk); #1;
        start    = 1'b1;
        load_len = 8'(len);
        @(posedge clk); #1;
        start    = 1'b0;
        load_len = 8'($urandom);
        for (int k = 0; k < bytes.size(); k++) begin
            if (abort_wr > 0 && k == 2*abort_wr) begin
                @(negedge clk); #1;
                check("writes_before_reset", 32'(wr_cnt - w0), 32'(abort_wr));
                check("write_at_reset", 32'(ic_write), 32'd1);
                reset = 1'b1;
                #1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_write", 32'(ic_write), 32'd0);
                check("rst_ready", 32'(rx_ready), 32'd0);
                check("rst_stall", 32'(cpu_stall), 32'd0);
                check("rst_index", ic_instruction_index, 32'd0);
                check("rst_instr", 32'(ic_instruction), 32'd0);
                check("rst_ic_index", ic_index, 32'd5);
                check("rst_not_enable", 32'(ic_not_enable), 32'd0);
                exp_q.delete();
                @(posedge clk); #1;
                reset    = 1'b0;
                rx_valid = 1'b0;
                repeat (6) begin @(posedge clk); #1; end
                check("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
                check("idle_after_reset", 32'(busy), 32'd0);
                return;
            end
            g = (gap >= 0) ? gap : int'($urandom_range(0, -gap));
            if (k == restart_at) g = 0;
            if (k == 0 || (k % 2) == 1) extra += g;
            else if (g > 0) extra += g - 1;
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            repeat (g) begin @(posedge clk); #1; end
            rx_valid = 1'b1;
            rx_data  = bytes[k];
            if (k == restart_at) begin
                start    = 1'b1;
                load_len = 8'd1;
            end
            t   = 0;
            rdy = 1'b0;
            while (!rdy && t < 64) begin
                @(negedge clk);
                rdy = rx_ready;
                @(posedge clk); #1;
                start = 1'b0;
                t++;
            end
            rx_valid = 1'b0;
            if (!rdy) begin
                check("rx_timeout", 32'd0, 32'd1);
                return;
            end
        end
        t = 0;
        while (done_cnt == d0 && t < 16) begin
            @(posedge clk);
            t++;
        end
        repeat (2) begin @(posedge clk); end
        #1;
        check("done_once", 32'(done_cnt - d0), 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'(exp_busy + extra));
        check("writes_made", 32'(wr_cnt - w0), 32'(len));
        check("writes_left", 32'(exp_q.size()), 32'd0);
        check("error", 32'(error), 32'(exp_err));
    endtask

    task automatic reject_load(input int len);
        int d0;
        d0       = done_cnt;
        busy_cnt = 0;
        @(posedge clk); #1;
        start    = 1'b1;
        load_len = 8'(len);
        @(posedge clk); #1;
        start    = 1'b0;
        repeat (4) begin @(posedge clk); end
        #1;
        check("reject_error", 32'(error), 32'd1);
        check("reject_busy", 32'(busy_cnt), 32'd0);
        check("reject_done", 32'(done_cnt - d0), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        load_len  = 8'd0;
        rx_valid  = 1'b0;
        rx_data   = 8'd0;
        cpu_fetch = 1'b0;
        cpu_index = 32'd0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(rx_ready), 32'd0);
        check("reset_write", 32'(ic_write), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_index", ic_instruction_index, 32'd0);
        check("reset_instr", 32'(ic_instruction), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Two words, back-to-back bytes; image pinned by hand.
        fixed_q = '{8'h34, 8'h12, 8'h78, 8'h56};
        run_load(2, 0, -1, 1'b0, 0);
        check("image_word0", 32'(cache_mem[0]), 32'h1234);
        check("image_word1", 32'(cache_mem[1]), 32'h5678);

        // Oversized length is refused; the next legal start clears the error.
        reject_load(200);
        run_load(1, 0, -1, 1'b0, 0);
        reject_load(129);
        run_load(128, 0, -1, 1'b0, 0);

        // Five idle cycles before every byte.
        run_load(3, 5, -1, 1'b0, 0);

        // Stray start during a load must not change its length.
        run_load(5, 0, 3, 1'b0, 0);

        // Empty load.
        run_load(0, 0, -1, 1'b0, 0);

        // Reset after two writes of a four-word load.
        rand_cpu = 1'b0;
        run_load(4, 0, -1, 1'b0, 2);
        rand_cpu = 1'b1;

        for (int n = 0; n < 8; n++) begin
            run_load(int'($urandom_range(1, 12)), -3, -1, 1'b0, 0);
        end

`ifdef ICACHE_LOADER_CHECKSUM_EN
        fixed_q = '{8'h01, 8'h02};
        run_load(1, 0, -1, 1'b0, 0);
        fixed_q = '{8'h01, 8'h02};
        run_load(1, 0, -1, 1'b1, 0);
        run_load(0, 0, -1, 1'b0, 0);
        run_load(6, -2, -1, 1'b1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/icache_loader.md
Name: icache_loader

Overview:
- Boot/reload controller for the instruction cache.
- Receives a halfword program image as a byte stream (valid/ready), assembles it into 16-bit instructions and drives the cache write port, one write per instruction at consecutive indices from 0.
- While loading, it owns the cache and stalls the CPU fetch path; when idle, it passes CPU fetch requests straight through to the cache read port.

Parameters:
- DEPTH, 128, number of 16-bit cache cells; the maximum legal load length.
- LEN_W, 8, width of the load length input.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load of load_len instructions.
- load_len  in  LEN_W  number of 16-bit instructions to load.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader accepts a byte this cycle.
- ic_write  out  1  cache write strobe.
- ic_instruction_index  out  32  cache write address.
- ic_instruction  out  16  cache write data.
- cpu_fetch  in  1  CPU requests an instruction.
- cpu_index  in  32  CPU fetch index.
- ic_index  out  32  cache read index.
- ic_not_enable  out  1  cache read disable.
- cpu_stall  out  1  CPU must hold its fetch.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at load completion.
- error  out  1  sticky; set on a rejected or corrupt load, cleared by the next accepted start.

Behaviour:
- Reset values of outputs: rx_ready=0, ic_write=0, ic_instruction_index=0, ic_instruction=0, busy=0, done=0, error=0, cpu_stall=0. ic_not_enable = !cpu_fetch and ic_index = cpu_index (idle pass-through).
- FSM states: IDLE, RX_LO, RX_HI, WRITE, FINISH.
- IDLE:
  - start with load_len==0 -> FINISH; no writes.
  - start with load_len>DEPTH -> error=1, stay IDLE, no writes.
  - Otherwise -> RX_LO; clear error, clear counter cnt to 0.
- RX_LO: rx_ready=1. On rx_valid&&rx_ready, latch low byte -> RX_HI.
- RX_HI: rx_ready=1. On handshake, latch high byte -> WRITE. Byte order is little-endian: the first byte is bits [7:0].
- WRITE:
  - rx_ready=0. ic_write=1 for exactly one full cycle with ic_instruction_index=cnt and ic_instruction={hi,lo}, all registered. The cache samples writes on negedge, so data must be stable during the high phase.
  - cnt increments at the end of the cycle.
  - If cnt+1==load_len -> FINISH, else -> RX_LO.
- FINISH: done=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE. cpu_stall=busy. ic_not_enable=1 while busy.
- ic_write is never asserted outside WRITE.
- load_len is captured on start; later changes to the input are ignored.
- start while busy is ignored.
- rx_valid low stalls indefinitely; there is no timeout.
- Latency per instruction: minimum 3 cycles (RX_LO, RX_HI, WRITE). A full 128-instruction load takes 384 cycles plus 1 for FINISH.
- Reset mid-load: immediate return to IDLE with all outputs at reset values. Cache contents are left partially written, and no done pulse is produced.
- Simultaneous start and cpu_fetch in IDLE: start wins from the next cycle. The fetch in the start cycle is still passed through.

Optional Feature:
- ICACHE_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, go to state RX_SUM (rx_ready=1) and accept one byte.
  - If it differs from the XOR of all image bytes -> error=1.
  - Then go to FINISH; done still pulses.
  - load_len==0 expects a checksum byte of 0x00.
- Undefined: no RX_SUM state; the last WRITE goes directly to FINISH.

Decomposition:
- Package icache_pkg holds:
  - ICACHE_DEPTH=128;
  - ICACHE_INDEX_W=32;
  - the loader state enum (IDLE, RX_LO, RX_HI, WRITE, RX_SUM, FINISH).
- No sub-module. The byte assembly and checksum are small enough to keep inline.

Test Plan:
- Reset, then start with load_len=2, stream 0x34,0x12,0x78,0x56 with no gaps -> ic_write pulses at index 0 data 0x1234 and index 1 data 0x5678; done pulses once; busy high 7 cycles.
- start with load_len=200 -> error=1, no ic_write, busy stays 0. A following start with load_len=1 clears error.
- load_len=3 with rx_valid deasserted for 5 cycles between bytes -> no extra writes, indices 0,1,2 in order, cpu_stall high throughout.
- Reset asserted after 2 writes of a 4-instruction load -> outputs return to reset values asynchronously; no done pulse; idle pass-through resumes (cpu_fetch=1, cpu_index=5 -> ic_index=5, ic_not_enable=0).
- start pulsed again mid-load -> ignored; the original load completes with the original length.
- CHECKSUM_EN: bytes 0x01,0x02 followed by checksum 0x03 -> error=0; checksum 0x00 -> error=1; done pulses in both cases.
